// File: rtl/pearson_hash_verify.sv
// Pearson hash verifier.
// Takes a message length and a reference digest with a start pulse, then folds
// msg_len bytes through a caller-supplied 256-entry permutation table, one
// byte per cycle. Afterwards it reports the digest and whether it equals the
// reference.
module pearson_hash_verify #(
  parameter logic [7:0] INIT_HASH = 8'h00
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [2047:0] perm_table,
  input  logic          start,
  input  logic [7:0]    msg_len,
  input  logic [7:0]    expected_hash,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          busy,
  output logic          done,
  output logic          match,
  output logic [7:0]    hash_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HASH    = 2'd1,
    COMPARE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;

  logic [7:0] r_hash;
  logic [7:0] r_remaining;
  logic [7:0] r_expected;
  logic [7:0] r_hashOut;
  logic       r_done;
  logic       r_match;

  logic [7:0] w_index;
  logic [7:0] w_lookup;
  logic       w_accept;
  logic       w_startAccept;

  // The table lookup is purely combinational. The registered result is what
  // keeps throughput at one byte per cycle.
  assign w_index       = r_hash ^ byte_data;
  assign w_lookup      = perm_table[{w_index, 3'b000} +: 8];
  assign w_accept      = byte_valid && (r_state == HASH);
  assign w_startAccept = start && (r_state == IDLE);

  assign byte_ready = (r_state == HASH);
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign match      = r_match;
  assign hash_out   = r_hashOut;

  // State register; reset drops any verification in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. An empty message skips hashing and goes straight to
  // COMPARE. Leaving HASH on the last byte guarantees no extra byte is taken.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_startAccept) begin
          w_stateNext = (msg_len != 8'd0) ? HASH : COMPARE;
        end
      end
      HASH: begin
        if (w_accept && (r_remaining == 8'd1)) begin
          w_stateNext = COMPARE;
        end
      end
      COMPARE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Datapath. Request fields are latched on start, the hash and remaining
  // count are updated on each accepted byte, and results are published from
  // COMPARE so done, match and hash_out change together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_hash      <= INIT_HASH;
      r_remaining <= 8'd0;
      r_expected  <= 8'd0;
      r_hashOut   <= 8'd0;
      r_match     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_startAccept) begin
            r_remaining <= msg_len;
            r_expected  <= expected_hash;
            r_hash      <= INIT_HASH;
          end
        end
        HASH: begin
          if (w_accept) begin
            r_hash      <= w_lookup;
            r_remaining <= r_remaining - 8'd1;
          end
        end
        COMPARE: begin
          r_hashOut <= r_hash;
          r_match   <= (r_hash == r_expected);
          r_done    <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pearson_hash_verify.sv
// Self-checking bench for pearson_hash_verify.
// Uses a table of vectors plus hand-written sequences. Expected results go into
// a scoreboard queue when start is driven and are checked when done pulses.
module tb_pearson_hash_verify;

  localparam logic [7:0] INIT = 8'h00;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [2047:0] permTable;
  logic          start;
  logic [7:0]    msgLen;
  logic [7:0]    expectedHash;
  logic          byteValid;
  logic [7:0]    byteData;
  logic          byteReady;
  logic          busy;
  logic          done;
  logic          match;
  logic [7:0]    hashOut;

  typedef struct packed {
    logic [1:0]      tableSel;
    logic [7:0]      len;
    logic [3:0][7:0] bytes;
    logic [7:0]      expected;
    logic [7:0]      expHash;
  } vec_t;

  typedef struct {
    logic [7:0] hash;
    logic       matchBit;
    int         startEdge;
    int         latency;
  } sbEntry_t;

  sbEntry_t   sb[$];
  sbEntry_t   sbHead;
  vec_t       vecs [7];
  logic [7:0] modelT [256];
  logic [7:0] msgBytes [16];

  int vectorCount   = 0;
  int missCount     = 0;
  int cycle         = 0;
  int acceptedCount = 0;
  int readyCount    = 0;
  int doneCount     = 0;

  pearson_hash_verify #(
    .INIT_HASH(INIT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .perm_table   (permTable),
    .start        (start),
    .msg_len      (msgLen),
    .expected_hash(expectedHash),
    .byte_valid   (byteValid),
    .byte_data    (byteData),
    .byte_ready   (byteReady),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .hash_out     (hashOut)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Edge counter used to measure start-to-done latency
  always @(posedge clock) cycle++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectorCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  // Monitor sampled on the falling edge, away from the active edge. At this
  // point the inputs show what the next rising edge will sample, and the
  // outputs show the result of the previous rising edge.
  always @(negedge clock) begin
    if (reset_n && byteValid && byteReady) acceptedCount++;
    if (byteReady) readyCount++;
    if (done) begin
      doneCount++;
      if (sb.size() == 0) begin
        vectorCount++;
        missCount++;
        $display("[TB] FAIL unexpectedDone: got done=1 with hashOut=%0h, wanted no pulse", hashOut);
      end else begin
        sbHead = sb.pop_front();
        checkOutput("hashOut", int'(hashOut), int'(sbHead.hash));
        checkOutput("match", int'(match), int'(sbHead.matchBit));
        // done is picked up by the rising edge that follows this sample
        if (sbHead.latency >= 0)
          checkOutput("latency", cycle + 1 - sbHead.startEdge, sbHead.latency);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // 0: identity, 1: inverse, 2: scrambled bijection (odd multiplier)
  task automatic setTable(input int sel);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      if (sel == 0)      modelT[i] = v;
      else if (sel == 1) modelT[i] = ~v;
      else               modelT[i] = 8'(i * 37 + 11);
      permTable[8*i +: 8] = modelT[i];
    end
  endtask

  function automatic logic [7:0] modelHash(input int len);
    logic [7:0] h;
    h = INIT;
    for (int i = 0; i < len; i++) h = modelT[h ^ msgBytes[i]];
    return h;
  endfunction

  function automatic vec_t mkVec(input int sel, input int len,
                                 input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3,
                                 input logic [7:0] exp, input logic [7:0] h);
    vec_t v;
    v.tableSel = 2'(sel);
    v.len      = 8'(len);
    v.bytes[0] = b0;
    v.bytes[1] = b1;
    v.bytes[2] = b2;
    v.bytes[3] = b3;
    v.expected = exp;
    v.expHash  = h;
    return v;
  endfunction

  // Pulse start for one edge and push the expected outcome to the scoreboard
  task automatic applyStimulus(input int len, input logic [7:0] expected,
                               input logic [7:0] expHash, input int latency);
    sbEntry_t e;
    msgLen       = 8'(len);
    expectedHash = expected;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    e.hash       = expHash;
    e.matchBit   = (expected == expHash);
    e.startEdge  = cycle;
    e.latency    = latency;
    sb.push_back(e);
  endtask

  // Drive msgBytes[0..len-1]; with gaps, byte_valid drops for one cycle between bytes
  task automatic feedBytes(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0) begin
        byteValid = 1'b0;
        tick();
      end
      byteValid = 1'b1;
      byteData  = msgBytes[i];
      tick();
    end
    byteValid = 1'b0;
  endtask

  // Returns just after the edge that raised done, still inside the done cycle
  task automatic waitDone(input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL %s: got no done within %0d cycles, wanted done", name, bound);
    end
  endtask

  int acc0;
  int rdy0;
  int done0;
  logic [7:0] h;

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    msgLen       = 8'd0;
    expectedHash = 8'd0;
    byteValid    = 1'b0;
    byteData     = 8'd0;
    setTable(0);

    vecs[0] = mkVec(0, 2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h03, 8'h03);
    vecs[1] = mkVec(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
    vecs[2] = mkVec(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[3] = mkVec(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00);
    vecs[4] = mkVec(2, 2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h45, 8'h45);
    vecs[5] = mkVec(0, 4, 8'hFF, 8'h0F, 8'hF0, 8'h01, 8'h01, 8'h01);
    vecs[6] = mkVec(1, 2, 8'h12, 8'h34, 8'h00, 8'h00, 8'h27, 8'h26);

    // Reset state
    repeat (3) tick();
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst byteReady", int'(byteReady), 0);
    checkOutput("rst done", int'(done), 0);
    checkOutput("rst match", int'(match), 0);
    checkOutput("rst hashOut", int'(hashOut), 0);
    reset_n = 1'b1;
    tick();

    // Table-driven vectors, byte_valid held high for the whole message
    for (int v = 0; v < 7; v++) begin
      setTable(int'(vecs[v].tableSel));
      for (int i = 0; i < 4; i++) msgBytes[i] = vecs[v].bytes[i];
      acc0 = acceptedCount;
      rdy0 = readyCount;
      applyStimulus(int'(vecs[v].len), vecs[v].expected, vecs[v].expHash, int'(vecs[v].len) + 2);
      feedBytes(int'(vecs[v].len), 1'b0);
      waitDone(20, $sformatf("vec%0d done", v));
      tick();
      checkOutput($sformatf("vec%0d accepted", v), acceptedCount - acc0, int'(vecs[v].len));
      checkOutput($sformatf("vec%0d readyCycles", v), readyCount - rdy0, int'(vecs[v].len));
    end

    // Toggling byte_valid; a byte offered after done must not be taken
    setTable(0);
    msgBytes[0] = 8'h10;
    msgBytes[1] = 8'h20;
    msgBytes[2] = 8'h40;
    acc0 = acceptedCount;
    applyStimulus(3, 8'h70, 8'h70, -1);
    feedBytes(3, 1'b1);
    waitDone(20, "seqA done");
    byteValid = 1'b1;
    byteData  = 8'h80;
    repeat (3) tick();
    byteValid = 1'b0;
    tick();
    checkOutput("seqA accepted", acceptedCount - acc0, 3);
    checkOutput("seqA held hashOut", int'(hashOut), 8'h70);
    checkOutput("seqA busy", int'(busy), 0);

    // Reset after one of three bytes aborts without done
    done0 = doneCount;
    applyStimulus(3, 8'h00, 8'h00, -1);
    byteValid = 1'b1;
    byteData  = 8'hAB;
    tick();
    byteValid = 1'b0;
    reset_n   = 1'b0;
    tick();
    tick();
    sb.delete();
    checkOutput("seqB rst busy", int'(busy), 0);
    checkOutput("seqB rst byteReady", int'(byteReady), 0);
    checkOutput("seqB rst hashOut", int'(hashOut), 0);
    checkOutput("seqB rst match", int'(match), 0);
    checkOutput("seqB no done", doneCount - done0, 0);
    reset_n     = 1'b1;
    msgBytes[0] = 8'h05;
    applyStimulus(1, 8'h05, 8'h05, 3);
    feedBytes(1, 1'b0);
    waitDone(20, "seqB done1");
    tick();
    applyStimulus(1, 8'h04, 8'h05, 3);
    feedBytes(1, 1'b0);
    waitDone(20, "seqB done2");
    tick();

    // Start pulses while busy (HASH and COMPARE) are ignored
    done0 = doneCount;
    acc0  = acceptedCount;
    applyStimulus(2, 8'h03, 8'h03, -1);
    byteValid = 1'b1;
    byteData  = 8'h01;
    tick();
    byteValid    = 1'b0;
    start        = 1'b1;
    msgLen       = 8'd5;
    expectedHash = 8'hAA;
    tick();
    start     = 1'b0;
    byteValid = 1'b1;
    byteData  = 8'h02;
    tick();
    byteValid = 1'b0;
    start     = 1'b1;
    msgLen    = 8'd9;
    waitDone(20, "seqC done");
    start = 1'b0;
    repeat (4) tick();
    checkOutput("seqC doneCount", doneCount - done0, 1);
    checkOutput("seqC accepted", acceptedCount - acc0, 2);
    checkOutput("seqC busy", int'(busy), 0);

    // Start in the cycle done is high is accepted
    applyStimulus(0, 8'h00, 8'h00, 2);
    waitDone(20, "seqD done1");
    msgBytes[0] = 8'h77;
    applyStimulus(1, 8'h77, 8'h77, 3);
    feedBytes(1, 1'b0);
    waitDone(20, "seqD done2");
    tick();

    // Random messages against the scrambled table, checked with the bench model
    setTable(2);
    for (int k = 0; k < 4; k++) begin
      int len;
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) msgBytes[i] = 8'($urandom_range(0, 255));
      h = modelHash(len);
      acc0 = acceptedCount;
      applyStimulus(len, (k % 2 == 1) ? (h ^ 8'h01) : h, h, len + 2);
      feedBytes(len, 1'b0);
      waitDone(30, $sformatf("rand%0d done", k));
      tick();
      checkOutput($sformatf("rand%0d accepted", k), acceptedCount - acc0, len);
    end

    checkOutput("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
